// File: rtl/cycle_sequencer_if.sv
// Bundles the control-unit-facing signals of the T-step / M-cycle sequencer.
// master = control unit side that drives ticks and decode hints, slave = sequencer.
interface cycle_sequencer_if;
   logic       i_Enable;
   logic       i_Wait;
   logic       i_IR_Fetch;
   logic       i_Halt;
   logic       i_Wake;
   logic [3:0] o_Cycle_Step;
   logic [7:0] o_Cycle_Count;
   logic       o_Fetch_Cycle;
   logic       o_M_Edge;
   logic       o_Halted;
   logic       o_Overrun;

   modport master (
      output i_Enable, i_Wait, i_IR_Fetch, i_Halt, i_Wake,
      input  o_Cycle_Step, o_Cycle_Count, o_Fetch_Cycle, o_M_Edge, o_Halted, o_Overrun
   );

   modport slave (
      input  i_Enable, i_Wait, i_IR_Fetch, i_Halt, i_Wake,
      output o_Cycle_Step, o_Cycle_Count, o_Fetch_Cycle, o_M_Edge, o_Halted, o_Overrun
   );
endinterface

// File: rtl/cycle_sequencer.sv
// One-hot T-step / M-cycle timing generator with standalone fetch, wait stalls and HALT/wake.
// Step and count are both registered so microcode blocks always see a consistent pair.
module cycle_sequencer (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   cycle_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t     r_State;
   logic [3:0] r_Step;
   logic [7:0] r_Count;
   logic       r_Overrun;

   state_t     w_State_Next;
   logic [3:0] w_Step_Next;
   logic [7:0] w_Count_Next;
   logic       w_Overrun_Next;

   logic       w_Advance;
   logic       w_M_Done;
   logic [3:0] w_Step_Rot;
   logic       w_Count_Legal;

   assign w_Advance = bus.i_Enable & ~bus.i_Wait;
   assign w_M_Done  = w_Advance & (r_Step == 4'b1000);

   // Any corrupted step code falls back to the address phase rather than propagating.
   always_comb begin
      w_Step_Rot = 4'b0001;
      case (r_Step)
         4'b0001: w_Step_Rot = 4'b0010;
         4'b0010: w_Step_Rot = 4'b0100;
         4'b0100: w_Step_Rot = 4'b1000;
         default: w_Step_Rot = 4'b0001;
      endcase
   end

   assign w_Count_Legal = (r_Count != 8'h00) && ((r_Count & (r_Count - 8'h01)) == 8'h00);

   always_comb begin
      w_State_Next   = r_State;
      w_Step_Next    = r_Step;
      w_Count_Next   = r_Count;
      w_Overrun_Next = r_Overrun;
      case (r_State)
         ST_FETCH: begin
            if (w_Advance) begin
               w_Step_Next = w_Step_Rot;
               if (w_M_Done) begin
                  w_State_Next = ST_RUN;
                  w_Count_Next = 8'h01;
               end
            end
         end
         ST_RUN: begin
            if (w_Advance) begin
               w_Step_Next = w_Step_Rot;
               if (w_M_Done) begin
                  if (bus.i_IR_Fetch && bus.i_Halt) begin
                     w_State_Next = ST_HALT;
                     w_Step_Next  = 4'b0000;
                     w_Count_Next = 8'h00;
                  end else if (bus.i_IR_Fetch) begin
                     w_Count_Next = 8'h01;
                  end else if (r_Count[7]) begin
                     w_Count_Next   = 8'h01;
                     w_Overrun_Next = 1'b1;
                  end else if (w_Count_Legal) begin
                     w_Count_Next = {r_Count[6:0], 1'b0};
                  end else begin
                     w_Count_Next = 8'h01;
                  end
               end
            end
         end
         ST_HALT: begin
            w_Step_Next  = 4'b0000;
            w_Count_Next = 8'h00;
            if (bus.i_Wake && bus.i_Enable) begin
               w_State_Next = ST_FETCH;
               w_Step_Next  = 4'b0001;
            end
         end
         default: begin
            w_State_Next = ST_FETCH;
            w_Step_Next  = 4'b0001;
            w_Count_Next = 8'h00;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_State   <= ST_FETCH;
         r_Step    <= 4'b0001;
         r_Count   <= 8'h00;
         r_Overrun <= 1'b0;
      end else begin
         r_State   <= w_State_Next;
         r_Step    <= w_Step_Next;
         r_Count   <= w_Count_Next;
         r_Overrun <= w_Overrun_Next;
      end
   end

   assign bus.o_Cycle_Step  = r_Step;
   assign bus.o_Cycle_Count = r_Count;
   assign bus.o_Fetch_Cycle = (r_State == ST_FETCH);
   assign bus.o_Halted      = (r_State == ST_HALT);
   assign bus.o_Overrun     = r_Overrun;
   assign bus.o_M_Edge      = (r_State != ST_HALT) & w_M_Done;

endmodule
